// File: rtl/mskaes_job_arbiter.sv
// Round-robin job arbiter that shares one masked AES-128 core among NREQ requesters.
// Optional macro MSKAES_ARB_FLUSH_EN zeroes the ciphertext holding register after a handshake or timeout abort.
module mskaes_job_arbiter #(
    parameter int d       = 2,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*128*d-1:0] req_sh_plaintext,
    input  logic [NREQ*128*d-1:0] req_sh_key,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [128*d-1:0]      resp_sh_ciphertext,
    output logic                  core_valid_in,
    input  logic                  core_ready,
    input  logic                  core_cipher_valid,
    output logic [128*d-1:0]      core_sh_plaintext,
    output logic [128*d-1:0]      core_sh_key,
    input  logic [128*d-1:0]      core_sh_ciphertext,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int SW  = 128 * d;
    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_rr;
    logic [IDW-1:0]  r_grant;
    logic            r_resp_valid;
    logic [IDW-1:0]  r_resp_id;
    logic [SW-1:0]   r_hold;
    logic            r_err;
    logic [WDW-1:0]  r_wdog;

    logic            w_pick_found;
    logic [IDW-1:0]  w_pick_id;
    logic [IDW-1:0]  w_rr_next;
    logic [SW-1:0]   w_core_pt;
    logic [SW-1:0]   w_core_key;
    logic [NREQ-1:0] w_req_ready;

    // Scan downward so the requester closest to the rr pointer is assigned last and wins.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[IDW'((int'(r_rr) + k) % NREQ)]) begin
                w_pick_found = 1'b1;
                w_pick_id    = IDW'((int'(r_rr) + k) % NREQ);
            end
        end
    end

    assign w_rr_next = (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + IDW'(1);

    always_comb begin
        w_core_pt   = '0;
        w_core_key  = '0;
        w_req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_state == S_ISSUE && r_grant == IDW'(i)) begin
                w_core_pt      = req_sh_plaintext[i*SW +: SW];
                w_core_key     = req_sh_key[i*SW +: SW];
                w_req_ready[i] = core_ready;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_rr         <= '0;
            r_grant      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_hold       <= '0;
            r_err        <= 1'b0;
            r_wdog       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        r_grant <= w_pick_id;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (core_ready) begin
                        r_rr    <= w_rr_next;
                        r_wdog  <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // core_ready is ignored here: the core may hold it high after fetching.
                    if (core_cipher_valid) begin
                        r_hold       <= core_sh_ciphertext;
                        r_resp_id    <= r_grant;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
`ifdef MSKAES_ARB_FLUSH_EN
                        r_hold  <= '0;
`endif
                    end else begin
                        r_wdog <= r_wdog + WDW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
`ifdef MSKAES_ARB_FLUSH_EN
                        r_hold       <= '0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready          = w_req_ready;
    assign core_valid_in      = (r_state == S_ISSUE);
    assign core_sh_plaintext  = w_core_pt;
    assign core_sh_key        = w_core_key;
    assign resp_valid         = r_resp_valid;
    assign resp_id            = r_resp_id;
    assign resp_sh_ciphertext = r_hold;
    assign busy               = (r_state != S_IDLE);
    assign err_timeout        = r_err;

endmodule

// File: tb/tb_mskaes_job_arbiter.sv
// Directed bench for mskaes_job_arbiter with a behavioural masked-core stand-in (fixed latency, FIPS-197 vector known).
module tb_mskaes_job_arbiter;

    localparam int D       = 2;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 3;
    localparam int SW      = 128 * D;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                  clk = 1'b0;
    logic                  nrst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*SW-1:0]    req_sh_plaintext;
    logic [NREQ*SW-1:0]    req_sh_key;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [0:0]            resp_id;
    logic [SW-1:0]         resp_sh_ciphertext;
    logic                  core_valid_in;
    logic                  core_ready;
    logic                  core_cipher_valid = 1'b0;
    logic [SW-1:0]         core_sh_plaintext;
    logic [SW-1:0]         core_sh_key;
    logic [SW-1:0]         core_sh_ciphertext = '0;
    logic                  busy;
    logic                  err_timeout;

    int tests = 0;
    int fails = 0;

    logic          core_nores = 1'b0;
    int            late_cnt   = 0;
    int            late_seen  = 0;
    int            lat_cnt    = 0;
    int            rdy0_cnt   = 0;
    logic [127:0]  job_pt;
    logic [127:0]  job_key;
    logic [SW-1:0] emitted  = '0;
    logic [SW-1:0] held_exp = '0;

    mskaes_job_arbiter #(.d(D), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .nrst               (nrst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_sh_plaintext   (req_sh_plaintext),
        .req_sh_key         (req_sh_key),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_id            (resp_id),
        .resp_sh_ciphertext (resp_sh_ciphertext),
        .core_valid_in      (core_valid_in),
        .core_ready         (core_ready),
        .core_cipher_valid  (core_cipher_valid),
        .core_sh_plaintext  (core_sh_plaintext),
        .core_sh_key        (core_sh_key),
        .core_sh_ciphertext (core_sh_ciphertext),
        .busy               (busy),
        .err_timeout        (err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] fake_enc(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    function automatic logic [SW-1:0] share(input logic [127:0] v);
        logic [127:0] m;
        m = {$urandom(), $urandom(), $urandom(), $urandom()};
        return {m, v ^ m};
    endfunction

    function automatic logic [127:0] jp(input int r, input int n);
        return {r[7:0], n[7:0], 112'h0123456789abcdef0123456789ab};
    endfunction

    function automatic logic [127:0] jk(input int r, input int n);
        return {112'hfedcba9876543210fedcba987654, n[7:0], r[7:0]};
    endfunction

    // Core stand-in: acts 2 time units after each falling edge so bench inputs have settled.
    always @(negedge clk) begin
        #2;
        core_cipher_valid = 1'b0;
        if (!nrst) begin
            lat_cnt = 0;
        end else begin
            if (late_cnt != late_seen) begin
                late_seen          = late_cnt;
                core_cipher_valid  = 1'b1;
                core_sh_ciphertext = {2{128'hdeadbeef_deadbeef_deadbeef_deadbeef}};
            end
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0 && !core_nores) begin
                    emitted            = share(fake_enc(job_pt, job_key));
                    core_sh_ciphertext = emitted;
                    core_cipher_valid  = 1'b1;
                end
            end
            if (core_valid_in && core_ready) begin
                job_pt  = core_sh_plaintext[127:0] ^ core_sh_plaintext[255:128];
                job_key = core_sh_key[127:0] ^ core_sh_key[255:128];
                lat_cnt = LAT;
            end
            if (req_ready[0]) rdy0_cnt++;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_job(input int r, input logic [127:0] pt, input logic [127:0] key);
        if (r == 0) begin
            req_sh_plaintext[SW-1:0] = share(pt);
            req_sh_key[SW-1:0]       = share(key);
        end else begin
            req_sh_plaintext[2*SW-1:SW] = share(pt);
            req_sh_key[2*SW-1:SW]       = share(key);
        end
    endtask

    function automatic logic [SW-1:0] req_pt_slice(input int r);
        return (r == 0) ? req_sh_plaintext[SW-1:0] : req_sh_plaintext[2*SW-1:SW];
    endfunction

    function automatic logic [SW-1:0] req_key_slice(input int r);
        return (r == 0) ? req_sh_key[SW-1:0] : req_sh_key[2*SW-1:SW];
    endfunction

    task automatic wait_ready(output int g);
        int n;
        n = 0;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", (req_ready != '0), 1);
        g = req_ready[1] ? 1 : 0;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("resp_wait", resp_valid, 1);
    endtask

    task automatic check_resp(input int exp_id, input logic [127:0] exp_ct);
        check("resp_id", resp_id, exp_id);
        check("resp_shares", resp_sh_ciphertext, emitted);
        check("resp_ct", resp_sh_ciphertext[127:0] ^ resp_sh_ciphertext[255:128], exp_ct);
        held_exp = emitted;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("idle_after_hs", busy, 0);
        check("valid_after_hs", resp_valid, 0);
`ifdef MSKAES_ARB_FLUSH_EN
        held_exp = '0;
`endif
        check("hold_after_hs", resp_sh_ciphertext, held_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "bench stuck");
    end

    initial begin
        int g;
        int base;
        int issued [2];
        logic [127:0] exp_ct;

        issued[0] = 0;
        issued[1] = 0;
        nrst             = 1'b0;
        req_valid        = '0;
        resp_ready       = 1'b0;
        core_ready       = 1'b1;
        req_sh_plaintext = '0;
        req_sh_key       = '0;

        // Contention: both requesters valid from reset.
        load_job(0, jp(0, 0), jk(0, 0));
        load_job(1, jp(1, 0), jk(1, 0));
        req_valid = 2'b11;
        #3;
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_core_valid", core_valid_in, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_hold", resp_sh_ciphertext, 0);
        check("rst_err", err_timeout, 0);
        check("rst_core_pt", core_sh_plaintext, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        for (int j = 0; j < 4; j++) begin
            wait_ready(g);
            check("rr_order", g, j % 2);
            check("core_pt_mux", core_sh_plaintext, req_pt_slice(g));
            check("core_key_mux", core_sh_key, req_key_slice(g));
            exp_ct = fake_enc(jp(g, issued[g]), jk(g, issued[g]));
            issued[g]++;
            @(negedge clk);
            if (issued[g] == 2) req_valid[g] = 1'b0;
            else load_job(g, jp(g, issued[g]), jk(g, issued[g]));
            wait_resp();
            check_resp(g, exp_ct);
            finish_resp();
        end

        // FIPS-197 vector on requester 0, with the core stalling ISSUE for two cycles.
        core_ready = 1'b0;
        load_job(0, FIPS_PT, FIPS_KEY);
        base = rdy0_cnt;
        req_valid = 2'b01;
        repeat (2) @(negedge clk);
        check("issue_hold_valid", core_valid_in, 1);
        check("issue_hold_ready", req_ready, 0);
        check("issue_hold_busy", busy, 1);
        core_ready = 1'b1;
        #1;
        check("issue_ready_pulse", req_ready, 2'b01);
        check("fips_key_mux", core_sh_key, req_key_slice(0));
        @(negedge clk);
        req_valid = '0;
        check("busy_no_valid", core_valid_in, 0);
        check("busy_pt_zero", core_sh_plaintext, 0);
        wait_resp();
        check_resp(0, FIPS_CT);
        check("fips_ready_pulses", rdy0_cnt - base, 1);
        finish_resp();

        // Backpressure: hold the response 20 cycles while requester 0 waits.
        load_job(1, jp(1, 5), jk(1, 5));
        req_valid = 2'b10;
        wait_ready(g);
        check("bp_grant", g, 1);
        exp_ct = fake_enc(jp(1, 5), jk(1, 5));
        @(negedge clk);
        req_valid = '0;
        wait_resp();
        check_resp(1, exp_ct);
        load_job(0, jp(0, 5), jk(0, 5));
        req_valid = 2'b01;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_valid", resp_valid, 1);
            check("bp_data", resp_sh_ciphertext, emitted);
            check("bp_no_issue", core_valid_in, 0);
        end
        finish_resp();
        wait_ready(g);
        check("post_bp_grant", g, 0);
        exp_ct = fake_enc(jp(0, 5), jk(0, 5));
        @(negedge clk);
        req_valid = '0;
        wait_resp();
        check_resp(0, exp_ct);
        finish_resp();

        // Watchdog: core never answers.
        core_nores = 1'b1;
        load_job(1, jp(1, 6), jk(1, 6));
        req_valid = 2'b10;
        wait_ready(g);
        check("to_grant", g, 1);
        @(negedge clk);
        req_valid = '0;
        repeat (15) @(negedge clk);
        check("to_err_before", err_timeout, 0);
        check("to_busy_before", busy, 1);
        @(negedge clk);
        check("to_err_after", err_timeout, 1);
        check("to_idle_after", busy, 0);
        check("to_no_resp", resp_valid, 0);
`ifdef MSKAES_ARB_FLUSH_EN
        held_exp = '0;
`endif
        check("to_hold", resp_sh_ciphertext, held_exp);
        late_cnt++;
        @(negedge clk);
        @(negedge clk);
        check("late_busy", busy, 0);
        check("late_no_resp", resp_valid, 0);
        check("late_hold", resp_sh_ciphertext, held_exp);
        core_nores = 1'b0;

        load_job(0, jp(0, 6), jk(0, 6));
        req_valid = 2'b01;
        wait_ready(g);
        check("after_to_grant", g, 0);
        exp_ct = fake_enc(jp(0, 6), jk(0, 6));
        @(negedge clk);
        req_valid = '0;
        wait_resp();
        check_resp(0, exp_ct);
        check("err_sticky", err_timeout, 1);
        finish_resp();

        // Async reset in the middle of BUSY; rr pointer is 1 before the reset.
        load_job(0, jp(0, 7), jk(0, 7));
        req_valid = 2'b01;
        wait_ready(g);
        check("pre_rst_grant", g, 0);
        @(negedge clk);
        req_valid = '0;
        check("pre_rst_busy", busy, 1);
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_core_valid", core_valid_in, 0);
        check("arst_resp_valid", resp_valid, 0);
        check("arst_resp_id", resp_id, 0);
        check("arst_hold", resp_sh_ciphertext, 0);
        check("arst_err", err_timeout, 0);
        check("arst_req_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        held_exp = '0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy, 0);
        check("post_rst_no_issue", core_valid_in, 0);
        load_job(0, jp(0, 8), jk(0, 8));
        load_job(1, jp(1, 8), jk(1, 8));
        req_valid = 2'b11;
        wait_ready(g);
        check("post_rst_grant", g, 0);
        exp_ct = fake_enc(jp(0, 8), jk(0, 8));
        @(negedge clk);
        req_valid = '0;
        wait_resp();
        check_resp(0, exp_ct);
        finish_resp();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
